// File: rtl/hwpe_engine_switch_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// hwpe_engine_switch_ctrl
//
// Owns the engine select and the clock-enable pair of the two-engine HWPE
// subsystem (engine 0 = neureka, engine 1 = datamover). A software switch
// request drains the active engine, gates its clock, flips the static TCDM
// mux, ungates the new engine and then pulses done. The sequencing keeps both
// clocks from ever running together and keeps the mux still while TCDM
// transactions are in flight.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   sw_valid_i/ready_o   switch request handshake, sw_tgt_i = requested engine
//   done_o               one-cycle pulse when a switch completes or aborts
//   err_o, err_clr_i     sticky error (drain timeout, counter over/underflow)
//   engine_busy_i        per-engine busy flags
//   tcdm_req_i/gnt_i     mux-side request/grant, counted as outstanding
//   tcdm_r_valid_i       mux-side response, retires one outstanding request
//   clk_en_o             per-engine clock enable
//   mux_sel_o            static TCDM mux select
//   active_valid_o       an engine has been enabled since reset
//   state_o              FSM state, for debug
// ---------------------------------------------------------------------------
module hwpe_engine_switch_ctrl #(
  parameter int MaxOutstanding = 8,
  parameter int SettleCycles   = 2,
  parameter int DrainTimeout   = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sw_valid_i,
  input  logic       sw_tgt_i,
  output logic       sw_ready_o,
  output logic       done_o,
  output logic       err_o,
  input  logic       err_clr_i,
  input  logic [1:0] engine_busy_i,
  input  logic       tcdm_req_i,
  input  logic       tcdm_gnt_i,
  input  logic       tcdm_r_valid_i,
  output logic [1:0] clk_en_o,
  output logic       mux_sel_o,
  output logic       active_valid_o,
  output logic [2:0] state_o
);

  localparam int OutW = $clog2(MaxOutstanding + 1);
  localparam int TmoW = $clog2(DrainTimeout + 1);
  localparam int SetW = $clog2(SettleCycles + 1);

  localparam logic [OutW-1:0] OutMax     = OutW'(MaxOutstanding);
  localparam logic [TmoW-1:0] TmoLimit   = TmoW'(DrainTimeout);
  localparam logic [SetW-1:0] SettleInit = SetW'(SettleCycles);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDrain  = 3'd1,
    StGate   = 3'd2,
    StSwitch = 3'd3,
    StUngate = 3'd4,
    StDone   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [OutW-1:0] outst_q, outst_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [SetW-1:0] settle_q, settle_d;
  logic [1:0]      clk_en_q, clk_en_d;
  logic            mux_sel_q, mux_sel_d;
  logic            active_q, active_d;
  logic            target_q, target_d;
  logic            err_q, err_d;

  logic            outst_inc, outst_dec;
  logic            outst_ovf, outst_unf;
  logic            drain_ok, tmo_hit, tmo_abort;

  // Outstanding TCDM request counter. A grant and a response in the same
  // cycle cancel out; otherwise the counter saturates at both ends and the
  // offending event is reported as an error instead of wrapping.
  always_comb begin
    outst_inc = tcdm_req_i & tcdm_gnt_i;
    outst_dec = tcdm_r_valid_i;
    outst_d   = outst_q;
    outst_ovf = 1'b0;
    outst_unf = 1'b0;
    if (outst_inc && !outst_dec) begin
      if (outst_q == OutMax) begin
        outst_ovf = 1'b1;
      end else begin
        outst_d = outst_q + 1'b1;
      end
    end else if (outst_dec && !outst_inc) begin
      if (outst_q == '0) begin
        outst_unf = 1'b1;
      end else begin
        outst_d = outst_q - 1'b1;
      end
    end
  end

  // The drain check looks at the post-update count so that GATE follows the
  // cycle carrying the last response directly. A new request this cycle
  // blocks the exit even if it is not yet granted.
  assign drain_ok  = !engine_busy_i[mux_sel_q] && (outst_d == '0) && !tcdm_req_i;
  assign tmo_hit   = (tmo_q == TmoLimit);
  assign tmo_abort = (state_q == StDrain) && !drain_ok && tmo_hit;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. In DRAIN a completed drain wins over an expiring
  // timeout, since the engine is safe to switch at that point.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (sw_valid_i) begin
          if (!active_q) begin
            state_d = StSwitch;
          end else if (sw_tgt_i == mux_sel_q) begin
            state_d = StDone;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (drain_ok) begin
          state_d = StGate;
        end else if (tmo_hit) begin
          state_d = StDone;
        end
      end
      StGate:   state_d = StSwitch;
      StSwitch: state_d = StUngate;
      StUngate: begin
        if (settle_q == '0) begin
          state_d = StDone;
        end
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath updates tied to the FSM. The settle counter is loaded on the
  // way into UNGATE so that UNGATE lasts SettleCycles+1 cycles, which is
  // SettleCycles cycles of the new clock running before done.
  always_comb begin
    target_d  = target_q;
    tmo_d     = tmo_q;
    settle_d  = settle_q;
    clk_en_d  = clk_en_q;
    mux_sel_d = mux_sel_q;
    active_d  = active_q;
    case (state_q)
      StIdle: begin
        if (sw_valid_i) begin
          target_d = sw_tgt_i;
          tmo_d    = '0;
        end
      end
      StDrain: begin
        if (!drain_ok && !tmo_hit) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StGate: begin
        clk_en_d = 2'b00;
      end
      StSwitch: begin
        mux_sel_d = target_q;
        settle_d  = SettleInit;
      end
      StUngate: begin
        clk_en_d = target_q ? 2'b10 : 2'b01;
        active_d = 1'b1;
        if (settle_q != '0) begin
          settle_d = settle_q - 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Sticky error; a set event in the same cycle as a clear keeps it set.
  always_comb begin
    err_d = err_q;
    if (outst_ovf || outst_unf || tmo_abort) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  // Datapath registers. Reset gates both engines and returns the select to
  // engine 0 immediately, even mid-switch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_q   <= '0;
      tmo_q     <= '0;
      settle_q  <= '0;
      clk_en_q  <= 2'b00;
      mux_sel_q <= 1'b0;
      active_q  <= 1'b0;
      target_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      outst_q   <= outst_d;
      tmo_q     <= tmo_d;
      settle_q  <= settle_d;
      clk_en_q  <= clk_en_d;
      mux_sel_q <= mux_sel_d;
      active_q  <= active_d;
      target_q  <= target_d;
      err_q     <= err_d;
    end
  end

  // Output decode from the current state.
  always_comb begin
    sw_ready_o = (state_q == StIdle);
    done_o     = (state_q == StDone);
    state_o    = state_q;
  end

  assign clk_en_o       = clk_en_q;
  assign mux_sel_o      = mux_sel_q;
  assign active_valid_o = active_q;
  assign err_o          = err_q;

  // Safety properties of the sequencing.
  a_never_both_en : assert property (@(posedge clk_i) disable iff (!rst_ni)
    clk_en_q != 2'b11);

  a_sel_only_gated : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mux_sel_q != $past(mux_sel_q)) |-> ($past(clk_en_q) == 2'b00));

endmodule
